// File: rtl/mem_lsu_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
// Requests are held stable until the memory acknowledges them.
interface mem_lsu_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/mem_lsu.sv
// MEM stage: forwards EX results to WB and runs one big-endian data-memory access at a time.
// Define MEM_LSU_ALIGN_CHECK_EN to reject misaligned halfword/word accesses with align_err_o.
module mem_lsu (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid_i,
    input  logic [4:0]       ex_wd_i,
    input  logic             ex_wreg_i,
    input  logic [31:0]      ex_wdata_i,
    input  logic [31:0]      ex_hi_i,
    input  logic [31:0]      ex_lo_i,
    input  logic             ex_whilo_i,
    input  logic [3:0]       ex_memop_i,
    input  logic [31:0]      ex_maddr_i,
    input  logic [31:0]      ex_mstore_i,
    input  logic             flush_i,
    mem_lsu_if.master        dmem,
    output logic [4:0]       wb_wd_o,
    output logic             wb_wreg_o,
    output logic [31:0]      wb_wdata_o,
    output logic [31:0]      wb_hi_o,
    output logic [31:0]      wb_lo_o,
    output logic             wb_whilo_o,
    output logic             stall_o,
    output logic             align_err_o
);

    typedef enum logic [0:0] {StIdle, StReq} state_e;

    localparam logic [3:0] OpNone = 4'd0;
    localparam logic [3:0] OpLb   = 4'd1;
    localparam logic [3:0] OpLbu  = 4'd2;
    localparam logic [3:0] OpLh   = 4'd3;
    localparam logic [3:0] OpLhu  = 4'd4;
    localparam logic [3:0] OpLw   = 4'd5;
    localparam logic [3:0] OpSb   = 4'd6;
    localparam logic [3:0] OpSh   = 4'd7;
    localparam logic [3:0] OpSw   = 4'd8;

    state_e      state_q, state_d;
    logic [4:0]  wd_q, wd_d;
    logic        wreg_q, wreg_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        whilo_q, whilo_d;
    logic [3:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [3:0]  be_q, be_d;
    logic        we_q, we_d;
    logic [31:0] req_wdata_q, req_wdata_d;
    logic [4:0]  wb_wd_q, wb_wd_d;
    logic        wb_wreg_q, wb_wreg_d;
    logic [31:0] wb_wdata_q, wb_wdata_d;
    logic [31:0] wb_hi_q, wb_hi_d;
    logic [31:0] wb_lo_q, wb_lo_d;
    logic        wb_whilo_q, wb_whilo_d;
    logic        align_err_q, align_err_d;

    logic        accept;
    logic [3:0]  op_eff;
    logic        misalign;
    logic        is_store_q;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign accept = ex_valid_i && !flush_i;
    // Undefined opcodes behave like plain ALU results.
    assign op_eff = (ex_memop_i >= OpLb && ex_memop_i <= OpSw) ? ex_memop_i : OpNone;
    assign is_store_q = (op_q == OpSb) || (op_q == OpSh) || (op_q == OpSw);

`ifdef MEM_LSU_ALIGN_CHECK_EN
    always_comb begin
        misalign = 1'b0;
        if (op_eff == OpLh || op_eff == OpLhu || op_eff == OpSh) begin
            misalign = ex_maddr_i[0];
        end else if (op_eff == OpLw || op_eff == OpSw) begin
            misalign = |ex_maddr_i[1:0];
        end
    end
`else
    assign misalign = 1'b0;
`endif

    // Big-endian lane select: offset 0 is the most significant byte.
    always_comb begin
        ld_byte = dmem.rdata[31:24];
        unique case (off_q)
            2'd0: ld_byte = dmem.rdata[31:24];
            2'd1: ld_byte = dmem.rdata[23:16];
            2'd2: ld_byte = dmem.rdata[15:8];
            2'd3: ld_byte = dmem.rdata[7:0];
            default: ld_byte = dmem.rdata[31:24];
        endcase
        ld_half = off_q[1] ? dmem.rdata[15:0] : dmem.rdata[31:16];
        unique case (op_q)
            OpLb:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            OpLbu:   ld_data = {24'd0, ld_byte};
            OpLh:    ld_data = {{16{ld_half[15]}}, ld_half};
            OpLhu:   ld_data = {16'd0, ld_half};
            default: ld_data = dmem.rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        wd_d        = wd_q;
        wreg_d      = wreg_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        whilo_d     = whilo_q;
        op_d        = op_q;
        off_d       = off_q;
        req_addr_d  = req_addr_q;
        be_d        = be_q;
        we_d        = we_q;
        req_wdata_d = req_wdata_q;
        wb_wd_d     = wb_wd_q;
        wb_wreg_d   = wb_wreg_q;
        wb_wdata_d  = wb_wdata_q;
        wb_hi_d     = wb_hi_q;
        wb_lo_d     = wb_lo_q;
        wb_whilo_d  = wb_whilo_q;
        align_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                wb_wd_d    = 5'd0;
                wb_wreg_d  = 1'b0;
                wb_wdata_d = 32'd0;
                wb_hi_d    = 32'd0;
                wb_lo_d    = 32'd0;
                wb_whilo_d = 1'b0;
                if (accept) begin
                    if (op_eff == OpNone) begin
                        wb_wd_d    = ex_wd_i;
                        wb_wreg_d  = ex_wreg_i;
                        wb_wdata_d = ex_wdata_i;
                        wb_hi_d    = ex_hi_i;
                        wb_lo_d    = ex_lo_i;
                        wb_whilo_d = ex_whilo_i;
                    end else if (misalign) begin
                        align_err_d = 1'b1;
                    end else begin
                        wd_d        = ex_wd_i;
                        wreg_d      = ex_wreg_i;
                        hi_d        = ex_hi_i;
                        lo_d        = ex_lo_i;
                        whilo_d     = ex_whilo_i;
                        op_d        = op_eff;
                        off_d       = ex_maddr_i[1:0];
                        req_addr_d  = {ex_maddr_i[31:2], 2'b00};
                        be_d        = 4'b1111;
                        we_d        = 1'b0;
                        req_wdata_d = ex_mstore_i;
                        unique case (op_eff)
                            OpSb: begin
                                we_d        = 1'b1;
                                be_d        = 4'b1000 >> ex_maddr_i[1:0];
                                req_wdata_d = {4{ex_mstore_i[7:0]}};
                            end
                            OpSh: begin
                                we_d        = 1'b1;
                                be_d        = ex_maddr_i[1] ? 4'b0011 : 4'b1100;
                                req_wdata_d = {2{ex_mstore_i[15:0]}};
                            end
                            OpSw: we_d = 1'b1;
                            default: ;
                        endcase
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                if (dmem.ack) begin
                    state_d    = StIdle;
                    wb_wd_d    = wd_q;
                    wb_hi_d    = hi_q;
                    wb_lo_d    = lo_q;
                    wb_whilo_d = whilo_q;
                    wb_wreg_d  = is_store_q ? 1'b0 : wreg_q;
                    wb_wdata_d = is_store_q ? 32'd0 : ld_data;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wd_q        <= 5'd0;
            wreg_q      <= 1'b0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            whilo_q     <= 1'b0;
            op_q        <= OpNone;
            off_q       <= 2'd0;
            req_addr_q  <= 32'd0;
            be_q        <= 4'd0;
            we_q        <= 1'b0;
            req_wdata_q <= 32'd0;
            wb_wd_q     <= 5'd0;
            wb_wreg_q   <= 1'b0;
            wb_wdata_q  <= 32'd0;
            wb_hi_q     <= 32'd0;
            wb_lo_q     <= 32'd0;
            wb_whilo_q  <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            wd_q        <= wd_d;
            wreg_q      <= wreg_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            whilo_q     <= whilo_d;
            op_q        <= op_d;
            off_q       <= off_d;
            req_addr_q  <= req_addr_d;
            be_q        <= be_d;
            we_q        <= we_d;
            req_wdata_q <= req_wdata_d;
            wb_wd_q     <= wb_wd_d;
            wb_wreg_q   <= wb_wreg_d;
            wb_wdata_q  <= wb_wdata_d;
            wb_hi_q     <= wb_hi_d;
            wb_lo_q     <= wb_lo_d;
            wb_whilo_q  <= wb_whilo_d;
            align_err_q <= align_err_d;
        end
    end

    assign dmem.req    = (state_q == StReq);
    assign dmem.we     = we_q;
    assign dmem.addr   = req_addr_q;
    assign dmem.be     = be_q;
    assign dmem.wdata  = req_wdata_q;
    assign stall_o     = (state_q == StReq);
    assign align_err_o = align_err_q;
    assign wb_wd_o     = wb_wd_q;
    assign wb_wreg_o   = wb_wreg_q;
    assign wb_wdata_o  = wb_wdata_q;
    assign wb_hi_o     = wb_hi_q;
    assign wb_lo_o     = wb_lo_q;
    assign wb_whilo_o  = wb_whilo_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Randomized bench for mem_lsu against a behavioural model of the memory-stage rules.
// Honours MEM_LSU_ALIGN_CHECK_EN the same way the design does.
module tb_mem_lsu;

    logic        clk;
    logic        rst;
    logic        ex_valid_i;
    logic [4:0]  ex_wd_i;
    logic        ex_wreg_i;
    logic [31:0] ex_wdata_i;
    logic [31:0] ex_hi_i;
    logic [31:0] ex_lo_i;
    logic        ex_whilo_i;
    logic [3:0]  ex_memop_i;
    logic [31:0] ex_maddr_i;
    logic [31:0] ex_mstore_i;
    logic        flush_i;
    logic [4:0]  wb_wd_o;
    logic        wb_wreg_o;
    logic [31:0] wb_wdata_o;
    logic [31:0] wb_hi_o;
    logic [31:0] wb_lo_o;
    logic        wb_whilo_o;
    logic        stall_o;
    logic        align_err_o;

    int total = 0;
    int bad   = 0;

`ifdef MEM_LSU_ALIGN_CHECK_EN
    localparam bit AlignCheck = 1'b1;
`else
    localparam bit AlignCheck = 1'b0;
`endif

    mem_lsu_if dmem_bus ();

    mem_lsu dut (
        .clk         (clk),
        .rst         (rst),
        .ex_valid_i  (ex_valid_i),
        .ex_wd_i     (ex_wd_i),
        .ex_wreg_i   (ex_wreg_i),
        .ex_wdata_i  (ex_wdata_i),
        .ex_hi_i     (ex_hi_i),
        .ex_lo_i     (ex_lo_i),
        .ex_whilo_i  (ex_whilo_i),
        .ex_memop_i  (ex_memop_i),
        .ex_maddr_i  (ex_maddr_i),
        .ex_mstore_i (ex_mstore_i),
        .flush_i     (flush_i),
        .dmem        (dmem_bus.master),
        .wb_wd_o     (wb_wd_o),
        .wb_wreg_o   (wb_wreg_o),
        .wb_wdata_o  (wb_wdata_o),
        .wb_hi_o     (wb_hi_o),
        .wb_lo_o     (wb_lo_o),
        .wb_whilo_o  (wb_whilo_o),
        .stall_o     (stall_o),
        .align_err_o (align_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference rules, written arithmetically from the byte-lane definitions.
    function automatic logic [31:0] model_load(input int op, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        int unsigned bidx = addr % 4;
        int unsigned hidx = (addr / 2) % 2;
        logic [31:0] b = (rdata >> (8 * (3 - bidx))) & 32'hFF;
        logic [31:0] h = (rdata >> (16 * (1 - hidx))) & 32'hFFFF;
        case (op)
            1: return (b >= 32'h80) ? b - 32'h100 : b;
            2: return b;
            3: return (h >= 32'h8000) ? h - 32'h10000 : h;
            4: return h;
            default: return rdata;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input int op, input logic [31:0] addr);
        int unsigned bidx = addr % 4;
        int unsigned hidx = (addr / 2) % 2;
        case (op)
            6: return 4'(1 << (3 - bidx));
            7: return 4'(3 << (2 * (1 - hidx)));
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input int op, input logic [31:0] store);
        case (op)
            6: return (store % 256) * 32'h0101_0101;
            7: return (store % 65536) * 32'h0001_0001;
            default: return store;
        endcase
    endfunction

    function automatic bit model_misaligned(input int op, input logic [31:0] addr);
        if (!AlignCheck) return 1'b0;
        if (op == 3 || op == 4 || op == 7) return (addr % 2) != 0;
        if (op == 5 || op == 8) return (addr % 4) != 0;
        return 1'b0;
    endfunction

    // Offers one instruction, then services its memory access (if any) with lat REQ cycles.
    task automatic run_op(input bit valid, input bit flush, input logic [3:0] op,
                          input logic [31:0] addr, input logic [31:0] store,
                          input logic [4:0] wd, input bit wreg, input bit whilo,
                          input logic [31:0] wdata, input logic [31:0] hi,
                          input logic [31:0] lo, input int lat, input logic [31:0] rdata);
        int  opn = (op >= 1 && op <= 8) ? int'(op) : 0;
        bit  acc = valid && !flush;
        bit  mis = acc && opn != 0 && model_misaligned(opn, addr);
        bit  is_store = (opn >= 6);
        ex_valid_i  = valid;
        flush_i     = flush;
        ex_memop_i  = op;
        ex_maddr_i  = addr;
        ex_mstore_i = store;
        ex_wd_i     = wd;
        ex_wreg_i   = wreg;
        ex_whilo_i  = whilo;
        ex_wdata_i  = wdata;
        ex_hi_i     = hi;
        ex_lo_i     = lo;
        dmem_bus.ack   = 1'($urandom % 2);
        dmem_bus.rdata = $urandom;
        tick();
        check("align_err", 32'(align_err_o), 32'(mis));
        if (!acc || mis) begin
            check("bubble_wreg", 32'(wb_wreg_o), 0);
            check("bubble_whilo", 32'(wb_whilo_o), 0);
            check("bubble_wdata", wb_wdata_o, 0);
            check("bubble_stall", 32'(stall_o), 0);
            check("bubble_req", 32'(dmem_bus.req), 0);
        end else if (opn == 0) begin
            check("pass_wd", 32'(wb_wd_o), 32'(wd));
            check("pass_wreg", 32'(wb_wreg_o), 32'(wreg));
            check("pass_wdata", wb_wdata_o, wdata);
            check("pass_hi", wb_hi_o, hi);
            check("pass_lo", wb_lo_o, lo);
            check("pass_whilo", 32'(wb_whilo_o), 32'(whilo));
            check("pass_stall", 32'(stall_o), 0);
        end else begin
            check("accept_wreg", 32'(wb_wreg_o), 0);
            check("accept_wdata", wb_wdata_o, 0);
            for (int i = 0; i < lat; i++) begin
                check("req_stall", 32'(stall_o), 1);
                check("req", 32'(dmem_bus.req), 1);
                check("req_addr", dmem_bus.addr, addr & 32'hFFFF_FFFC);
                check("req_we", 32'(dmem_bus.we), 32'(is_store));
                check("req_be", 32'(dmem_bus.be), 32'(model_be(opn, addr)));
                if (is_store) check("req_wdata", dmem_bus.wdata, model_wdata(opn, store));
                // Upstream traffic and flush during the access must be ignored.
                ex_valid_i = 1'($urandom % 2);
                flush_i    = 1'($urandom % 2);
                ex_memop_i = 4'($urandom);
                dmem_bus.ack   = (i == lat - 1);
                dmem_bus.rdata = (i == lat - 1) ? rdata : $urandom;
                tick();
            end
            dmem_bus.ack = 1'b0;
            check("done_stall", 32'(stall_o), 0);
            check("done_req", 32'(dmem_bus.req), 0);
            check("done_wd", 32'(wb_wd_o), 32'(wd));
            check("done_wreg", 32'(wb_wreg_o), is_store ? 0 : 32'(wreg));
            check("done_whilo", 32'(wb_whilo_o), 32'(whilo));
            check("done_hi", wb_hi_o, hi);
            check("done_lo", wb_lo_o, lo);
            check("done_wdata", wb_wdata_o, is_store ? 0 : model_load(opn, addr, rdata));
        end
    endtask

    initial begin
        rst = 1'b0;
        ex_valid_i = 0; ex_wd_i = 0; ex_wreg_i = 0; ex_wdata_i = 0; ex_hi_i = 0;
        ex_lo_i = 0; ex_whilo_i = 0; ex_memop_i = 0; ex_maddr_i = 0; ex_mstore_i = 0;
        flush_i = 0;
        dmem_bus.ack = 1'b0;
        dmem_bus.rdata = 32'd0;
        tick();
        tick();
        check("rst_stall", 32'(stall_o), 0);
        check("rst_req", 32'(dmem_bus.req), 0);
        check("rst_we", 32'(dmem_bus.we), 0);
        check("rst_be", 32'(dmem_bus.be), 0);
        check("rst_addr", dmem_bus.addr, 0);
        check("rst_wdata", dmem_bus.wdata, 0);
        check("rst_wb_wreg", 32'(wb_wreg_o), 0);
        check("rst_wb_wdata", wb_wdata_o, 0);
        check("rst_align_err", 32'(align_err_o), 0);
        rst = 1'b1;

        // Directed cases from the verification list.
        run_op(1, 0, 4'd0, 0, 0, 5'd5, 1, 0, 32'h1234, 0, 0, 1, 0);
        run_op(1, 0, 4'd1, 32'h1001, 0, 5'd7, 1, 0, 0, 0, 0, 3, 32'h0080_FF00);
        run_op(1, 0, 4'd2, 32'h1001, 0, 5'd7, 1, 0, 0, 0, 0, 3, 32'h0080_FF00);
        run_op(1, 0, 4'd7, 32'h2002, 32'hABCD, 5'd3, 1, 1, 0, 32'h11, 32'h22, 1, 0);
        run_op(1, 0, 4'd5, 32'h3002, 0, 5'd9, 1, 0, 0, 0, 0, 2, 32'hCAFE_F00D);
        run_op(1, 0, 4'd0, 0, 0, 5'd1, 1, 0, 32'h55, 0, 0, 1, 0);
        run_op(1, 1, 4'd5, 32'h40, 0, 5'd2, 1, 0, 0, 0, 0, 1, 0);

        // Reset while an access is pending abandons it.
        ex_valid_i = 1; flush_i = 0; ex_memop_i = 4'd5; ex_maddr_i = 32'h40; ex_wreg_i = 1;
        tick();
        check("rstreq_req", 32'(dmem_bus.req), 1);
        ex_valid_i = 0;
        rst = 1'b0;
        tick();
        check("rstreq_req_drop", 32'(dmem_bus.req), 0);
        check("rstreq_stall", 32'(stall_o), 0);
        check("rstreq_wreg", 32'(wb_wreg_o), 0);
        rst = 1'b1;
        dmem_bus.ack = 1'b1;
        tick();
        check("late_ack_wreg", 32'(wb_wreg_o), 0);
        check("late_ack_stall", 32'(stall_o), 0);
        dmem_bus.ack = 1'b0;

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a = $urandom;
            if ($urandom % 2 == 0) a = a & 32'hFFFF_FFFC;
            run_op(($urandom % 8) != 0, ($urandom % 8) == 0, 4'($urandom), a, $urandom,
                   5'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                   1 + int'($urandom % 4), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
